// File: rtl/vram_wr_queue.sv
// VRAM port-b write queue: buffers CPU write commands, commits them only inside the i_wr_allow window.
// Latency: a popped entry drives port b on the next cycle, one entry per cycle while draining.
// Backpressure: o_cmd_ready = !full. Optional statistics outputs are enabled by VRAM_WR_STATS_EN.

module vram_wr_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push_vld && !full;
    assign do_pop  = pop_vld && !empty;
    assign pop_dat = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

module vram_wr_queue #(
    parameter  int DEPTH  = 16,
    parameter  int ADDR_W = 12,
    parameter  int DATA_W = 64,
    localparam int BE_W   = DATA_W / 8,
    localparam int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [1:0]        i_cmd_ram,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [DATA_W-1:0] i_cmd_data,
    input  logic [BE_W-1:0]   i_cmd_byteena,
    input  logic              i_wr_allow,
    output logic [ADDR_W-1:0] o_addr_b,
    output logic [DATA_W-1:0] o_wrdata_b,
    output logic [BE_W-1:0]   o_byteena_b,
    output logic [3:0]        o_wren_b,
    output logic              o_busy,
    output logic [LVL_W-1:0]  o_level
`ifdef VRAM_WR_STATS_EN
    ,
    input  logic              i_stat_clr,
    output logic [15:0]       o_stat_commits,
    output logic [LVL_W-1:0]  o_stat_maxlvl
`endif
);
    typedef struct packed {
        logic [1:0]        ram;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [BE_W-1:0]   be;
    } cmd_t;

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t state;
    state_t state_nxt;
    cmd_t   push_cmd;
    cmd_t   head;
    logic   full;
    logic   empty;
    logic   push_acc;
    logic   pop;

    assign o_cmd_ready = !full;
    assign push_acc    = i_cmd_valid && o_cmd_ready;
    assign push_cmd    = '{ram: i_cmd_ram, addr: i_cmd_addr, data: i_cmd_data, be: i_cmd_byteena};

    vram_wr_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (i_cmd_valid),
        .push_dat (push_cmd),
        .pop_vld  (pop),
        .pop_dat  (head),
        .full     (full),
        .empty    (empty),
        .level    (o_level)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Leave DRAIN as soon as the window closes or the last queued entry goes out.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (i_wr_allow && !empty) state_nxt = DRAIN;
            end
            DRAIN: begin
                pop = i_wr_allow && !empty;
                if (!i_wr_allow || empty || (o_level == LVL_W'(1) && !push_acc))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Port-b bus holds its last value; only the write enable is a single-cycle pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_addr_b    <= '0;
            o_wrdata_b  <= '0;
            o_byteena_b <= '0;
            o_wren_b    <= '0;
        end else begin
            o_wren_b <= '0;
            if (pop) begin
                o_addr_b    <= head.addr;
                o_wrdata_b  <= head.data;
                o_byteena_b <= head.be;
                if (|head.be) o_wren_b <= 4'b0001 << head.ram;
            end
        end
    end

    assign o_busy = (o_level != '0) || (|o_wren_b);

`ifdef VRAM_WR_STATS_EN
    always_ff @(posedge clk) begin
        if (reset || i_stat_clr) begin
            o_stat_commits <= '0;
            o_stat_maxlvl  <= '0;
        end else begin
            if ((|o_wren_b) && (o_stat_commits != 16'hFFFF))
                o_stat_commits <= o_stat_commits + 16'd1;
            if (o_level > o_stat_maxlvl)
                o_stat_maxlvl <= o_level;
        end
    end
`endif
endmodule

// File: tb/tb_vram_wr_queue.sv
// Directed bench for vram_wr_queue: hold, drain order, full, window pause, zero byteena, reset mid-drain.
module tb_vram_wr_queue;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 64;
    localparam int BE_W   = 8;
    localparam int LVL_W  = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_cmd_valid;
    logic              o_cmd_ready;
    logic [1:0]        i_cmd_ram;
    logic [ADDR_W-1:0] i_cmd_addr;
    logic [DATA_W-1:0] i_cmd_data;
    logic [BE_W-1:0]   i_cmd_byteena;
    logic              i_wr_allow;
    logic [ADDR_W-1:0] o_addr_b;
    logic [DATA_W-1:0] o_wrdata_b;
    logic [BE_W-1:0]   o_byteena_b;
    logic [3:0]        o_wren_b;
    logic              o_busy;
    logic [LVL_W-1:0]  o_level;
`ifdef VRAM_WR_STATS_EN
    logic              i_stat_clr;
    logic [15:0]       o_stat_commits;
    logic [LVL_W-1:0]  o_stat_maxlvl;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    vram_wr_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_cmd_valid   (i_cmd_valid),
        .o_cmd_ready   (o_cmd_ready),
        .i_cmd_ram     (i_cmd_ram),
        .i_cmd_addr    (i_cmd_addr),
        .i_cmd_data    (i_cmd_data),
        .i_cmd_byteena (i_cmd_byteena),
        .i_wr_allow    (i_wr_allow),
        .o_addr_b      (o_addr_b),
        .o_wrdata_b    (o_wrdata_b),
        .o_byteena_b   (o_byteena_b),
        .o_wren_b      (o_wren_b),
        .o_busy        (o_busy),
        .o_level       (o_level)
`ifdef VRAM_WR_STATS_EN
        ,
        .i_stat_clr     (i_stat_clr),
        .o_stat_commits (o_stat_commits),
        .o_stat_maxlvl  (o_stat_maxlvl)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; i_wr_allow = 1'b0; i_cmd_valid = 1'b0;
        i_cmd_ram = '0; i_cmd_addr = '0; i_cmd_data = '0; i_cmd_byteena = '0;
`ifdef VRAM_WR_STATS_EN
        i_stat_clr = 1'b0;
`endif
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic push(input logic [1:0] ram, input logic [11:0] addr,
                        input logic [63:0] data, input logic [7:0] be);
        i_cmd_valid = 1'b1; i_cmd_ram = ram; i_cmd_addr = addr;
        i_cmd_data = data; i_cmd_byteena = be;
        step();
        i_cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (o_cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", o_cmd_ready); end
        tests++; if (o_wren_b !== 4'b0000) begin fails++; $display("FAIL reset_wren got %b exp 0000", o_wren_b); end
        tests++; if ({o_addr_b, o_wrdata_b, o_byteena_b} !== '0) begin fails++; $display("FAIL reset_bus got %h %h %h exp 0", o_addr_b, o_wrdata_b, o_byteena_b); end
        tests++; if ({o_busy, o_level} !== 6'd0) begin fails++; $display("FAIL reset_busy_level got %b %0d exp 0 0", o_busy, o_level); end
`ifdef VRAM_WR_STATS_EN
        tests++; if ({o_stat_commits, o_stat_maxlvl} !== '0) begin fails++; $display("FAIL reset_stats got %0d %0d exp 0 0", o_stat_commits, o_stat_maxlvl); end
`endif
    endtask

    task automatic test_hold();
        do_reset();
        push(2'd0, 12'h010, 64'h0123_4567_89AB_CDEF, 8'hFF);
        tests++; if (o_wren_b !== 4'b0000) begin fails++; $display("FAIL hold_wren_first got %b exp 0000", o_wren_b); end
        push(2'd2, 12'h020, 64'hFEDC_BA98_7654_3210, 8'hF0);
        push(2'd3, 12'h030, 64'h5555_AAAA_5555_AAAA, 8'h0F);
        repeat (3) step();
        tests++; if (o_wren_b !== 4'b0000) begin fails++; $display("FAIL hold_wren got %b exp 0000", o_wren_b); end
        tests++; if (o_level !== 5'd3) begin fails++; $display("FAIL hold_level got %0d exp 3", o_level); end
        tests++; if (o_busy !== 1'b1) begin fails++; $display("FAIL hold_busy got %b exp 1", o_busy); end
    endtask

    task automatic test_drain();
        logic [3:0]  ew [3] = '{4'b0001, 4'b0100, 4'b1000};
        logic [11:0] ea [3] = '{12'h010, 12'h020, 12'h030};
        logic [63:0] ed [3] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h5555_AAAA_5555_AAAA};
        logic [7:0]  eb [3] = '{8'hFF, 8'hF0, 8'h0F};
        int k = 0;
        int prev = 0;
        i_wr_allow = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            if (o_wren_b !== 4'b0000) begin
                if (k < 3) begin
                    tests++;
                    if ({o_wren_b, o_addr_b, o_wrdata_b, o_byteena_b} !== {ew[k], ea[k], ed[k], eb[k]}) begin
                        fails++; $display("FAIL drain_write%0d got %b %h %h %h exp %b %h %h %h", k,
                            o_wren_b, o_addr_b, o_wrdata_b, o_byteena_b, ew[k], ea[k], ed[k], eb[k]);
                    end
                end
                if (k > 0) begin
                    tests++; if (c != prev + 1) begin fails++; $display("FAIL drain_consec write%0d at cycle %0d exp %0d", k, c, prev + 1); end
                end
                prev = c;
                k++;
            end
        end
        tests++; if (k != 3) begin fails++; $display("FAIL drain_count got %0d exp 3", k); end
        tests++; if ({o_level, o_busy} !== 6'd0) begin fails++; $display("FAIL drain_idle got level %0d busy %b exp 0 0", o_level, o_busy); end
    endtask

    task automatic test_fill();
        int k = 0;
        logic [3:0] ew;
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            push(2'(i), 12'(i), 64'hF000_0000_0000_0000 | 64'(i), 8'hFF);
        tests++; if ({o_cmd_ready, o_level} !== {1'b0, 5'd16}) begin fails++; $display("FAIL fill_full got ready %b level %0d exp 0 16", o_cmd_ready, o_level); end
        push(2'd1, 12'hFFF, 64'hDEAD_DEAD_DEAD_DEAD, 8'hFF);
        tests++; if (o_level !== 5'd16) begin fails++; $display("FAIL fill_17th got level %0d exp 16", o_level); end
        i_wr_allow = 1'b1;
        for (int c = 0; c < 40; c++) begin
            step();
            if (o_wren_b !== 4'b0000) begin
                if (k < DEPTH) begin
                    ew = 4'b0001 << (k % 4);
                    tests++;
                    if ({o_wren_b, o_addr_b, o_wrdata_b} !== {ew, 12'(k), 64'hF000_0000_0000_0000 | 64'(k)}) begin
                        fails++; $display("FAIL fill_write%0d got %b %h %h exp %b %h", k, o_wren_b, o_addr_b, o_wrdata_b, ew, 12'(k));
                    end
                end
                k++;
            end
        end
        tests++; if (k != DEPTH) begin fails++; $display("FAIL fill_count got %0d exp 16", k); end
        i_wr_allow = 1'b0;
    endtask

    task automatic test_pause();
        int k = 0;
        int seen = 0;
        do_reset();
        for (int i = 0; i < 5; i++)
            push(2'(i), 12'h100 + 12'(i), 64'hC0DE_0000_0000_0000 | 64'(i), 8'hFF);
        i_wr_allow = 1'b1;
        for (int c = 0; c < 8 && o_wren_b === 4'b0000; c++) step();
        tests++; if (o_addr_b !== 12'h100 || o_wren_b !== 4'b0001) begin fails++; $display("FAIL pause_first got %b %h exp 0001 100", o_wren_b, o_addr_b); end
        step();
        tests++; if (o_addr_b !== 12'h101 || o_wren_b !== 4'b0010) begin fails++; $display("FAIL pause_second got %b %h exp 0010 101", o_wren_b, o_addr_b); end
        i_wr_allow = 1'b0;
        step();
        tests++; if ({o_wren_b, o_level} !== {4'b0000, 5'd3}) begin fails++; $display("FAIL pause_stop got wren %b level %0d exp 0000 3", o_wren_b, o_level); end
        for (int c = 0; c < 3; c++) begin step(); if (o_wren_b !== 4'b0000) seen++; end
        tests++; if (seen != 0) begin fails++; $display("FAIL pause_hold got %0d writes exp 0", seen); end
        i_wr_allow = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (o_wren_b !== 4'b0000) begin
                if (k < 3) begin
                    tests++; if (o_addr_b !== 12'h102 + 12'(k)) begin fails++; $display("FAIL pause_resume%0d got %h exp %h", k, o_addr_b, 12'h102 + 12'(k)); end
                end
                k++;
            end
        end
        tests++; if (k != 3) begin fails++; $display("FAIL pause_resume_count got %0d exp 3", k); end
        i_wr_allow = 1'b0;
    endtask

    task automatic test_zero_be();
        int k = 0;
        int first = 0;
        do_reset();
        push(2'd1, 12'h0A1, 64'h1111_2222_3333_4444, 8'h0F);
        push(2'd2, 12'h0A2, 64'h9999_9999_9999_9999, 8'h00);
        push(2'd0, 12'h0A3, 64'h7777_8888_9999_AAAA, 8'hFF);
        i_wr_allow = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            if (o_wren_b !== 4'b0000) begin
                if (k == 0) begin
                    first = c;
                    tests++; if ({o_wren_b, o_addr_b, o_byteena_b} !== {4'b0010, 12'h0A1, 8'h0F}) begin fails++; $display("FAIL zbe_first got %b %h %h exp 0010 0a1 0f", o_wren_b, o_addr_b, o_byteena_b); end
                end else if (k == 1) begin
                    tests++; if ({o_wren_b, o_addr_b, c} !== {4'b0001, 12'h0A3, first + 2}) begin fails++; $display("FAIL zbe_second got %b %h cycle %0d exp 0001 0a3 %0d", o_wren_b, o_addr_b, c, first + 2); end
                end
                k++;
            end
        end
        tests++; if (k != 2) begin fails++; $display("FAIL zbe_count got %0d exp 2", k); end
        i_wr_allow = 1'b0;
    endtask

    task automatic test_back_to_back();
        int k = 0;
        int prev = 0;
        do_reset();
        i_wr_allow = 1'b1;
        for (int c = 0; c < 16; c++) begin
            i_cmd_valid = (c < 4); i_cmd_ram = 2'(3 - c); i_cmd_addr = 12'h200 + 12'(c);
            i_cmd_data = 64'(c) << 8; i_cmd_byteena = 8'h3C;
            step();
            if (o_wren_b !== 4'b0000) begin
                if (k < 4) begin
                    tests++; if ({o_wren_b, o_addr_b} !== {4'b1000 >> k, 12'h200 + 12'(k)}) begin fails++; $display("FAIL b2b_write%0d got %b %h exp %b %h", k, o_wren_b, o_addr_b, 4'b1000 >> k, 12'h200 + 12'(k)); end
                end
                if (k > 0) begin
                    tests++; if (c != prev + 1) begin fails++; $display("FAIL b2b_consec write%0d at %0d exp %0d", k, c, prev + 1); end
                end
                prev = c;
                k++;
            end
        end
        tests++; if (k != 4) begin fails++; $display("FAIL b2b_count got %0d exp 4", k); end
        i_wr_allow = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        int seen = 0;
        do_reset();
        for (int i = 0; i < 4; i++) push(2'd0, 12'h300 + 12'(i), 64'hAB, 8'hFF);
        i_wr_allow = 1'b1;
        for (int c = 0; c < 8 && o_wren_b === 4'b0000; c++) step();
        tests++; if (o_wren_b !== 4'b0001) begin fails++; $display("FAIL rst_mid_start got %b exp 0001", o_wren_b); end
        reset = 1'b1;
        step();
        tests++; if ({o_wren_b, o_level, o_busy, o_cmd_ready} !== {4'b0000, 5'd0, 1'b0, 1'b1}) begin fails++; $display("FAIL rst_mid_state got wren %b level %0d busy %b ready %b exp 0000 0 0 1", o_wren_b, o_level, o_busy, o_cmd_ready); end
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin step(); if (o_wren_b !== 4'b0000) seen++; end
        tests++; if (seen != 0) begin fails++; $display("FAIL rst_mid_discard got %0d writes exp 0", seen); end
        i_wr_allow = 1'b0;
    endtask

`ifdef VRAM_WR_STATS_EN
    task automatic test_stats();
        do_reset();
        for (int i = 0; i < 5; i++) push(2'(i), 12'h400 + 12'(i), 64'h5, 8'h01);
        i_wr_allow = 1'b1;
        repeat (12) step();
        tests++; if ({o_stat_commits, o_stat_maxlvl} !== {16'd5, 5'd5}) begin fails++; $display("FAIL stats_count got %0d %0d exp 5 5", o_stat_commits, o_stat_maxlvl); end
        i_stat_clr = 1'b1;
        step();
        i_stat_clr = 1'b0;
        tests++; if ({o_stat_commits, o_stat_maxlvl} !== '0) begin fails++; $display("FAIL stats_clr got %0d %0d exp 0 0", o_stat_commits, o_stat_maxlvl); end
        i_wr_allow = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_hold();
        test_drain();
        test_fill();
        test_pause();
        test_zero_be();
        test_back_to_back();
        test_reset_mid_drain();
`ifdef VRAM_WR_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
